// File: rtl/image_proc_pkg.sv
// Shared types and sizes for the image_processing pipeline (pooling and dense stages).
package image_proc_pkg;

  localparam int FEAT_W = 21;
  localparam int POOL_W = 24;
  localparam int POOL_H = 24;

  typedef logic signed [FEAT_W-1:0] feat_t;
  typedef logic [4:0]               pool_coord_t;

endpackage

// File: rtl/pool_line_buffer.sv
// One row of partial 2x2 maxima: DEPTH x DATA_W LUT RAM with per-entry valid bits,
// one write port, one asynchronous read port, a read-clear and a whole-buffer clear.
module pool_line_buffer #(
  parameter int DEPTH  = 24,
  parameter int DATA_W = 21,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clear_all_in,
  input  logic                     wr_en_in,
  input  logic [AW-1:0]            wr_addr_in,
  input  logic signed [DATA_W-1:0] wr_data_in,
  input  logic [AW-1:0]            rd_addr_in,
  input  logic                     rd_clr_in,
  output logic signed [DATA_W-1:0] rd_data_out,
  output logic                     rd_valid_out
);

  logic signed [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]         valid_reg;

  // Data storage has no reset; the valid bits alone decide whether an entry is used.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_reg[wr_addr_in] <= wr_data_in;
    end
  end

  // Per-entry valid bit: a write wins over the frame-start clear in the same cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en_in && (wr_addr_in == AW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end else if (clear_all_in || (rd_clr_in && (rd_addr_in == AW'(gi)))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign rd_data_out  = mem_reg[rd_addr_in];
  assign rd_valid_out = valid_reg[rd_addr_in];

endmodule

// File: rtl/maxpool_relu.sv
// Streaming 2x2 max-pool followed by optional ReLU; raster-order input, one pooled
// value per odd/odd input, two-cycle latency, no frame storage.
module maxpool_relu
  import image_proc_pkg::*;
#(
  parameter int IN_W    = 48,
  parameter int IN_H    = 48,
  parameter int DATA_W  = FEAT_W,
  parameter int RELU_EN = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     data_valid_in,
  input  logic signed [DATA_W-1:0] pixel_data_in,
  input  logic [5:0]               hcount_in,
  input  logic [5:0]               vcount_in,
  output logic                     data_valid_out,
  output logic signed [DATA_W-1:0] pixel_data_out,
  output logic [4:0]               hcount_out,
  output logic [4:0]               vcount_out,
  output logic                     frame_done_out
);

  localparam int PW = IN_W / 2;
  localparam int PH = IN_H / 2;
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic                     accept;
  logic                     odd_h;
  logic                     odd_v;
  logic [AW-1:0]            lb_addr;
  logic signed [DATA_W-1:0] m_next;
  logic signed [DATA_W-1:0] p_next;
  logic signed [DATA_W-1:0] lb_rd_data;
  logic                     lb_rd_valid;
  logic                     lb_clear_all;
  logic                     lb_wr_en;
  logic                     lb_rd_clr;

  logic signed [DATA_W-1:0] hold_reg;
  logic                     hold_tag_reg;
  logic signed [DATA_W-1:0] p_reg;
  pool_coord_t              ph_reg;
  pool_coord_t              pv_reg;
  logic                     s1_valid_reg;
  logic                     s1_last_reg;

  // Input qualification and the combinational horizontal/vertical max of the window.
  always_comb begin
    accept       = data_valid_in
                   && ({1'b0, hcount_in} < 7'(IN_W))
                   && ({1'b0, vcount_in} < 7'(IN_H));
    odd_h        = hcount_in[0];
    odd_v        = vcount_in[0];
    lb_addr      = AW'(hcount_in >> 1);
    m_next       = hold_tag_reg ? smax(hold_reg, pixel_data_in) : pixel_data_in;
    p_next       = lb_rd_valid ? smax(lb_rd_data, m_next) : m_next;
    lb_clear_all = accept && (hcount_in == 6'd0) && (vcount_in == 6'd0);
    lb_wr_en     = accept && odd_h && !odd_v;
    lb_rd_clr    = accept && odd_h && odd_v;
  end

  pool_line_buffer #(
    .DEPTH  (PW),
    .DATA_W (DATA_W)
  ) u_line_buffer (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clear_all_in (lb_clear_all),
    .wr_en_in     (lb_wr_en),
    .wr_addr_in   (lb_addr),
    .wr_data_in   (m_next),
    .rd_addr_in   (lb_addr),
    .rd_clr_in    (lb_rd_clr),
    .rd_data_out  (lb_rd_data),
    .rd_valid_out (lb_rd_valid)
  );

  // Stage 1: horizontal hold register and launch of completed windows with their tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_reg     <= '0;
      hold_tag_reg <= 1'b0;
      p_reg        <= '0;
      ph_reg       <= '0;
      pv_reg       <= '0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= 1'b0;
      if (accept) begin
        if (!odd_h) begin
          hold_reg     <= pixel_data_in;
          hold_tag_reg <= 1'b1;
        end else begin
          hold_tag_reg <= 1'b0;
          if (odd_v) begin
            s1_valid_reg <= 1'b1;
            p_reg        <= p_next;
            ph_reg       <= pool_coord_t'(hcount_in >> 1);
            pv_reg       <= pool_coord_t'(vcount_in >> 1);
            s1_last_reg  <= ((hcount_in >> 1) == 6'(PW - 1))
                            && ((vcount_in >> 1) == 6'(PH - 1));
          end
        end
      end
    end
  end

  // Stage 2: ReLU and output register; data and coordinates hold between strobes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_valid_out <= 1'b0;
      pixel_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      frame_done_out <= 1'b0;
    end else begin
      data_valid_out <= s1_valid_reg;
      frame_done_out <= s1_valid_reg && s1_last_reg;
      if (s1_valid_reg) begin
        pixel_data_out <= ((RELU_EN != 0) && p_reg[DATA_W-1]) ? '0 : p_reg;
        hcount_out     <= ph_reg;
        vcount_out     <= pv_reg;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_relu.sv
// Scoreboard bench for maxpool_relu: a frame-level reference model pushes expected
// pooled values on every input; a negedge monitor pops and compares each output.
module tb_maxpool_relu;

  localparam int IN_W = 48;
  localparam int IN_H = 48;
  localparam int DW   = 21;
  localparam int RELU = 1;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 data_valid_in;
  logic signed [DW-1:0] pixel_data_in;
  logic [5:0]           hcount_in;
  logic [5:0]           vcount_in;
  logic                 data_valid_out;
  logic signed [DW-1:0] pixel_data_out;
  logic [4:0]           hcount_out;
  logic [4:0]           vcount_out;
  logic                 frame_done_out;

  always #5 clk_in = ~clk_in;

  maxpool_relu #(
    .IN_W    (IN_W),
    .IN_H    (IN_H),
    .DATA_W  (DW),
    .RELU_EN (RELU)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_valid_in  (data_valid_in),
    .pixel_data_in  (pixel_data_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_out (data_valid_out),
    .pixel_data_out (pixel_data_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .frame_done_out (frame_done_out)
  );

  typedef struct {
    int data;
    int h;
    int v;
    bit fd;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  bit   seen [IN_H][IN_W];
  int   val  [IN_H][IN_W];

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void model_clear();
    for (int y = 0; y < IN_H; y++)
      for (int x = 0; x < IN_W; x++)
        seen[y][x] = 1'b0;
  endfunction

  // Reference: a pooled value is the max of whatever members of its 2x2 window have
  // been seen since the current frame started, then ReLU.
  function automatic void model(int x, int h, int v);
    int best;
    exp_t e;
    if (h == 0 && v == 0) model_clear();
    seen[v][h] = 1'b1;
    val[v][h]  = x;
    if ((h % 2 == 1) && (v % 2 == 1)) begin
      best = x;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++)
          if (seen[v-1+dy][h-1+dx] && val[v-1+dy][h-1+dx] > best)
            best = val[v-1+dy][h-1+dx];
      if (RELU != 0 && best < 0) best = 0;
      e.data = best;
      e.h    = h / 2;
      e.v    = v / 2;
      e.fd   = (h / 2 == IN_W / 2 - 1) && (v / 2 == IN_H / 2 - 1);
      e.due  = cyc + 2;
      q.push_back(e);
    end
  endfunction

  task automatic chk(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic drive(bit vld, int x, int h, int v);
    @(posedge clk_in);
    #1;
    data_valid_in = vld;
    pixel_data_in = DW'(x);
    hcount_in     = 6'(h);
    vcount_in     = 6'(v);
    if (vld && h < IN_W && v < IN_H) model(x, h, v);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
  endtask

  function automatic int pix(int mode, int h, int v);
    if (mode == 0) return v * IN_W + h;
    if (mode == 1) return -(v * IN_W + h);
    if ($urandom_range(0, 15) == 0) return -(1 << (DW - 1));
    return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
  endfunction

  // One raster frame; pct = chance (%) of a valid input per cycle, oor interleaves
  // out-of-range inputs, and (stop_v, stop_h) ends the frame early at that pixel.
  task automatic frame(int mode, int pct, bit oor, int stop_v, int stop_h);
    for (int v = 0; v < IN_H; v++) begin
      for (int h = 0; h < IN_W; h++) begin
        if (v == stop_v && h == stop_h) return;
        while (pct < 100 && $urandom_range(0, 99) >= pct) drive(1'b0, 0, 0, 0);
        if (oor && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 1) drive(1'b1, 1 << 19, 50, v);
          else                           drive(1'b1, 1 << 19, h, 49);
        end
        drive(1'b1, pix(mode, h, v), h, v);
      end
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, int'(data_valid_out), 0);
    chk({tag, "_data"},  int'(pixel_data_out), 0);
    chk({tag, "_hcount"}, int'(hcount_out), 0);
    chk({tag, "_vcount"}, int'(vcount_out), 0);
    chk({tag, "_frame_done"}, int'(frame_done_out), 0);
  endtask

  // Monitor: flag overdue expectations, then compare every presented output.
  always @(negedge clk_in) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL missing_output: got nothing by cycle %0d, required data=%0d at (%0d,%0d) in cycle %0d",
               cyc, e.data, e.h, e.v, e.due);
    end
    if (data_valid_out) begin
      n_vec++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%0d at (%0d,%0d) cycle %0d, required no output",
                 pixel_data_out, hcount_out, vcount_out, cyc);
      end else begin
        e = q.pop_front();
        if (int'(pixel_data_out) != e.data || int'(hcount_out) != e.h ||
            int'(vcount_out) != e.v || frame_done_out != e.fd || cyc != e.due) begin
          n_fail++;
          $display("FAIL pooled_output: got data=%0d (%0d,%0d) fd=%0d cycle=%0d, required data=%0d (%0d,%0d) fd=%0d cycle=%0d",
                   pixel_data_out, hcount_out, vcount_out, frame_done_out, cyc,
                   e.data, e.h, e.v, e.fd, e.due);
        end
      end
    end else if (frame_done_out) begin
      n_vec++;
      n_fail++;
      $display("FAIL frame_done_alone: got frame_done=1 without valid, required 0");
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in        = 1'b1;
    data_valid_in = 1'b0;
    pixel_data_in = '0;
    hcount_in     = '0;
    vcount_in     = '0;
    model_clear();
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset_state");
    rst_in = 1'b0;
    idle(2);

    // Ramp frame, negated frame (ReLU to zero).
    frame(0, 100, 1'b0, -1, -1);
    idle(4);
    frame(1, 100, 1'b0, -1, -1);
    idle(4);

    // Single windows: mixed values, then all most-negative.
    drive(1'b1, 5, 0, 0);
    drive(1'b1, -3, 1, 0);
    drive(1'b1, -(1 << 20), 0, 1);
    drive(1'b1, 7, 1, 1);
    idle(4);
    for (int i = 0; i < 4; i++) drive(1'b1, -(1 << 20), i % 2, i / 2);
    idle(4);

    // Gaps, random data, out-of-range interleaving.
    frame(0, 30, 1'b0, -1, -1);
    idle(4);
    frame(2, 100, 1'b0, -1, -1);
    idle(4);
    frame(2, 50, 1'b1, -1, -1);
    idle(4);
    frame(0, 100, 1'b1, -1, -1);
    idle(4);

    // Reset after row 17, then a clean frame.
    frame(0, 100, 1'b0, 18, 0);
    @(posedge clk_in);
    #1;
    rst_in        = 1'b1;
    data_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    q.delete();
    model_clear();
    check_zero("after_reset");
    rst_in = 1'b0;
    idle(5);
    frame(2, 100, 1'b0, -1, -1);
    idle(4);

    // Restart at (0,0) in the middle of a row pair, no reset.
    frame(0, 100, 1'b0, 17, 20);
    frame(2, 70, 1'b0, -1, -1);
    idle(6);
    chk("drain_pending", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
